// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
//   state_t  : controller states (IDLE, CALC, FIX)
//   count_w  : bit width needed to count partial-product steps 0..w
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Width of a counter able to hold the value w.
  function automatic int unsigned count_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mul_cond_neg.sv
// Conditional two's-complement negation.
//   din    : W-bit input value
//   neg    : 1 = output -din, 0 = pass din through
//   dout_c : W-bit combinational result
module mul_cond_neg #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout_c
);

  assign dout_c = neg ? W'(-din) : din;

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier, one partial-product step per clock,
// unsigned or two's-complement operands selected per operation.
//   clk, rst_n   : clock (rising edge), async active-low reset
//   start        : request, sampled only while idle
//   signed_mode  : 1 = two's complement operands, 0 = unsigned
//   multiplier   : operand Q, latched on accept
//   multiplicand : operand M, latched on accept
//   product      : 2*WIDTH result, held until the next completion
//   busy         : high from the accepting edge until the completion edge
//   done         : one-cycle completion pulse
import mul_pkg::*;

module mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CW = count_w(WIDTH);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   q_r;
  logic [WIDTH-1:0]   m_r;
  logic [CW-1:0]      count;
  logic               neg_r;

  logic [WIDTH-1:0]   q_abs_c;
  logic [WIDTH-1:0]   m_abs_c;
  logic               neg_in_c;
  logic [WIDTH:0]     sum_c;
  logic [2*WIDTH-1:0] prod_c;

  // Magnitudes of the incoming operands; only negated in signed mode.
  mul_cond_neg #(.W(WIDTH)) u_abs_q (
    .din    (multiplier),
    .neg    (signed_mode & multiplier[WIDTH-1]),
    .dout_c (q_abs_c)
  );

  mul_cond_neg #(.W(WIDTH)) u_abs_m (
    .din    (multiplicand),
    .neg    (signed_mode & multiplicand[WIDTH-1]),
    .dout_c (m_abs_c)
  );

  // Restore the sign of the unsigned magnitude product.
  mul_cond_neg #(.W(2*WIDTH)) u_fix (
    .din    ({acc[WIDTH-1:0], q_r}),
    .neg    (neg_r),
    .dout_c (prod_c)
  );

  assign neg_in_c = signed_mode & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);

  // Partial-product add; the extra acc bit keeps the carry.
  always_comb begin
    sum_c = acc;
    if (q_r[0]) sum_c = acc + {1'b0, m_r};
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (count == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      q_r     <= '0;
      m_r     <= '0;
      count   <= '0;
      neg_r   <= 1'b0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg_r <= neg_in_c;
            q_r   <= q_abs_c;
            m_r   <= m_abs_c;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          // {acc, q_r} <= {sum, q_r} >> 1
          acc   <= sum_c >> 1;
          q_r   <= {sum_c[0], q_r[WIDTH-1:1]};
          count <= count + CW'(1);
        end
        FIX: begin
          product <= prod_c;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
